// File: rtl/muldiv_hilo_writer.sv
// muldiv_hilo_writer: iterative MULT/MULTU/DIV/DIVU unit that writes HI/LO.
// Writes go to the HI/LO storage held in decode, through one-cycle strobes.
// Sequence: IDLE -> CALC (XLEN cycles) -> FIX (1) -> DONE (1) -> IDLE.
// Optional feature macro: MULDIV_MTHILO_EN enables a single-cycle MTHI/MTLO
// write path from IDLE. With the macro undefined, mt_hi, mt_lo and mt_data are ignored.
module muldiv_hilo_writer #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] DIVZERO_LO = {XLEN{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            mt_hi,
  input  logic            mt_lo,
  input  logic [XLEN-1:0] mt_data,
  output logic            busy,
  output logic [XLEN-1:0] hi_data,
  output logic [XLEN-1:0] wb_data,
  output logic            hi_write,
  output logic            lo_write
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  // Per-operation control flags, captured when the op launches.
  typedef struct packed {
    logic is_div;   // divide (else multiply)
    logic neg_lo;   // negate product / quotient
    logic neg_rem;  // negate remainder (dividend was negative)
    logic div0;     // divisor is zero: result overridden
  } opctl_t;

  state_t            state;
  opctl_t            ctl;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   a_raw;    // raw dividend, HI result on divide by zero
  logic [XLEN-1:0]   b_mag;    // multiplicand / divisor magnitude
  // acc_hi: upper product half (multiply) or partial remainder (divide).
  // acc_lo: multiplier shifting out (multiply) or dividend/quotient (divide).
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;

  // Launch-time decode of operand magnitudes and sign handling.
  logic              op_signed;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   a_mag_in;
  logic [XLEN-1:0]   b_mag_in;
  opctl_t            ctl_in;

  // Iteration datapath.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;  // remainder shifted left with next dividend bit
  logic [XLEN:0]     div_diff;   // trial subtraction; MSB set means restore

  // Sign-fixed results presented in FIX.
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   hi_res;
  logic [XLEN-1:0]   lo_res;

  // Operand decode: signed ops run on magnitudes, unsigned ops on raw values.
  always_comb begin
    op_signed     = op[0];
    sign_a        = op_signed & a[XLEN-1];
    sign_b        = op_signed & b[XLEN-1];
    a_mag_in      = sign_a ? (~a + 1'b1) : a;
    b_mag_in      = sign_b ? (~b + 1'b1) : b;
    ctl_in.is_div  = op[1];
    ctl_in.neg_lo  = sign_a ^ sign_b;
    ctl_in.neg_rem = sign_a;
    ctl_in.div0    = op[1] & (b == '0);
  end

  // One iteration step: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
  end

  // Sign correction and divide-by-zero override of the raw results.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = ctl.neg_lo  ? (~prod + 1'b1)   : prod;
    quo_fix  = ctl.neg_lo  ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix  = ctl.neg_rem ? (~acc_hi + 1'b1) : acc_hi;
    if (!ctl.is_div) begin
      hi_res = prod_fix[2*XLEN-1:XLEN];
      lo_res = prod_fix[XLEN-1:0];
    end else if (ctl.div0) begin
      hi_res = a_raw;
      lo_res = DIVZERO_LO;
    end else begin
      hi_res = rem_fix;
      lo_res = quo_fix;
    end
  end

`ifndef MULDIV_MTHILO_EN
  // Move-to inputs have no function in this build.
  logic mt_unused;
  assign mt_unused = ^{mt_hi, mt_lo, mt_data};
`endif

  // Control FSM, datapath registers and registered write strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ctl      <= '0;
      cnt      <= '0;
      a_raw    <= '0;
      b_mag    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy     <= 1'b0;
      hi_data  <= '0;
      wb_data  <= '0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      hi_write <= 1'b0;
      lo_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            // Abort beats a same-cycle launch.
            state <= S_IDLE;
          end else if (start) begin
            ctl    <= ctl_in;
            a_raw  <= a;
            b_mag  <= b_mag_in;
            acc_hi <= '0;
            acc_lo <= a_mag_in;
            cnt    <= CNT_W'(XLEN - 1);
            busy   <= 1'b1;
            state  <= S_CALC;
          end
`ifdef MULDIV_MTHILO_EN
          else if (mt_hi || mt_lo) begin
            // Direct move: pulse only the matching strobe, no stall.
            if (mt_hi) begin
              hi_write <= 1'b1;
              hi_data  <= mt_data;
            end
            if (mt_lo) begin
              lo_write <= 1'b1;
              wb_data  <= mt_data;
            end
          end
`endif
        end

        S_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (ctl.is_div) begin
              if (div_diff[XLEN]) begin
                acc_hi <= div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
              end else begin
                acc_hi <= div_diff[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
              end
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            if (cnt == '0) begin
              state <= S_FIX;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end

        S_FIX: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            hi_data  <= hi_res;
            wb_data  <= lo_res;
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            state    <= S_DONE;
          end
        end

        S_DONE: begin
          // The strobe is already on the bus here; flush cannot retract it.
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
